// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// sub exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, cin,
`ifdef SERIAL_ADD_SUB_EN
    output sub,
`endif
    output out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin,
`ifdef SERIAL_ADD_SUB_EN
    input  sub,
`endif
    input  out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder time-shared LSB first over WIDTH bits.
// Define SERIAL_ADD_SUB_EN to add the sub (A-B) mode.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  serial_add_ctrl_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             cy;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;

  logic             fa_s;
  logic             fa_co;
  logic             last;
  logic [WIDTH-1:0] b_ld;
  logic             cy_ld;
  logic [WIDTH-1:0] s_nxt;

  full_adder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (cy),
    .s  (fa_s),
    .co (fa_co)
  );

`ifdef SERIAL_ADD_SUB_EN
  // A-B as A + ~B + 1; cin has no meaning here
  assign b_ld  = bus.sub ? ~bus.b : bus.b;
  assign cy_ld = bus.sub ? 1'b1 : bus.cin;
`else
  assign b_ld  = bus.b;
  assign cy_ld = bus.cin;
`endif

  assign last  = (cnt == CW'(WIDTH - 1));
  assign s_nxt = {fa_s, s_sh[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      s_sh   <= '0;
      cy     <= 1'b0;
      cnt    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh  <= bus.a;
            b_sh  <= b_ld;
            cy    <= cy_ld;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          s_sh <= s_nxt;
          cy   <= fa_co;
          cnt  <= cnt + CW'(1);
          // cy here is still the carry into the MSB
          if (last) begin
            sum_r  <= s_nxt;
            cout_r <= fa_co;
            ovf_r  <= cy ^ fa_co;
            state  <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == RUN) || (state == DONE);
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH = 8.
// Sub-mode vectors run when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   ncmp = 0;
  int   nfail = 0;
  int   cyc = 0;

  serial_add_ctrl_if #(.WIDTH(8)) bus ();

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sub,
                        output int acc_cyc);
    int n;
    bus.a = a;
    bus.b = b;
    bus.cin = cin;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub = sub;
`endif
    bus.in_valid = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    if (n >= 40) begin
      ncmp++;
      nfail++;
      $display("FAIL accept_timeout: in_ready=%b want 1", bus.in_ready);
    end
    step();
    acc_cyc = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    if (n >= 40) n = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    ncmp++;
    if (bus.in_ready !== 1'b1) begin
      nfail++;
      $display("FAIL rst_in_ready: got %b want 1", bus.in_ready);
    end
    ncmp++;
    if ({bus.out_valid, bus.busy, bus.cout, bus.ovf} !== 4'b0) begin
      nfail++;
      $display("FAIL rst_flags: got %b want 0000",
               {bus.out_valid, bus.busy, bus.cout, bus.ovf});
    end
    ncmp++;
    if (bus.sum !== 8'h00) begin
      nfail++;
      $display("FAIL rst_sum: got %h want 00", bus.sum);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_add(input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic [7:0] es,
                          input logic ec, input logic eo);
    int t, n;
    accept(a, b, cin, 1'b0, t);
    ncmp++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      nfail++;
      $display("FAIL run_flags: busy=%b in_ready=%b want 1 0",
               bus.busy, bus.in_ready);
    end
    wait_out(n);
    // accept edge is k; out_valid seen after edge k+8
    ncmp++;
    if (n !== 8) begin
      nfail++;
      $display("FAIL latency: got %0d want 8", n);
    end
    ncmp++;
    if ({bus.sum, bus.cout, bus.ovf} !== {es, ec, eo}) begin
      nfail++;
      $display("FAIL add_%h_%h: got %h c%b o%b want %h c%b o%b",
               a, b, bus.sum, bus.cout, bus.ovf, es, ec, eo);
    end
    step();
    ncmp++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      nfail++;
      $display("FAIL release: in_ready=%b out_valid=%b want 1 0",
               bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_sub(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] es, input logic ec,
                          input logic eo);
    int t, n;
    // cin=0 must be ignored in sub mode
    accept(a, b, 1'b0, 1'b1, t);
    wait_out(n);
    ncmp++;
    if (n !== 8 || {bus.sum, bus.cout, bus.ovf} !== {es, ec, eo}) begin
      nfail++;
      $display("FAIL sub_%h_%h: n=%0d got %h c%b o%b want %h c%b o%b",
               a, b, n, bus.sum, bus.cout, bus.ovf, es, ec, eo);
    end
    step();
`ifdef SERIAL_ADD_SUB_EN
    bus.sub = 1'b0;
`endif
  endtask

  task automatic test_backpressure();
    int t, n;
    bus.out_ready = 1'b0;
    accept(8'h21, 8'h43, 1'b0, 1'b0, t);
    step();
    step();
    bus.a = 8'hEE;
    bus.b = 8'hEE;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    wait_out(n);
    ncmp++;
    if (n < 0 || bus.sum !== 8'h64) begin
      nfail++;
      $display("FAIL bp_result: n=%0d sum=%h want 64", n, bus.sum);
    end
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      ncmp++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.sum !== 8'h64 || bus.busy !== 1'b1) begin
        nfail++;
        $display("FAIL bp_hold%0d: ov=%b ir=%b sum=%h want 1 0 64",
                 i, bus.out_valid, bus.in_ready, bus.sum);
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    ncmp++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      nfail++;
      $display("FAIL bp_release: ir=%b ov=%b want 1 0",
               bus.in_ready, bus.out_valid);
    end
    step();
    step();
    ncmp++;
    if (bus.busy !== 1'b0 || bus.sum !== 8'h64) begin
      nfail++;
      $display("FAIL bp_no_second: busy=%b sum=%h want 0 64",
               bus.busy, bus.sum);
    end
  endtask

  task automatic test_reset_mid_run();
    int t, n;
    bit seen;
    accept(8'h55, 8'h11, 1'b0, 1'b0, t);
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    ncmp++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.cout, bus.ovf}
        !== 5'b10000 || bus.sum !== 8'h00) begin
      nfail++;
      $display("FAIL midrun_rst: ir=%b ov=%b busy=%b sum=%h want 1 0 0 00",
               bus.in_ready, bus.out_valid, bus.busy, bus.sum);
    end
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    ncmp++;
    if (seen !== 1'b0) begin
      nfail++;
      $display("FAIL midrun_ghost: out_valid=1 want 0");
    end
    accept(8'h10, 8'h20, 1'b1, 1'b0, t);
    wait_out(n);
    ncmp++;
    if (n !== 8 || bus.sum !== 8'h31) begin
      nfail++;
      $display("FAIL after_rst: n=%0d sum=%h want 8 31", n, bus.sum);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] va [3] = '{8'h12, 8'hA5, 8'h80};
    logic [7:0] vb [3] = '{8'h34, 8'h5A, 8'h80};
    logic       vc [3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] vs [3] = '{8'h46, 8'h00, 8'h00};
    logic       vo [3] = '{1'b0, 1'b1, 1'b1};
    int t, tp, n;
    bus.out_ready = 1'b1;
    tp = 0;
    for (int i = 0; i < 3; i++) begin
      accept(va[i], vb[i], vc[i], 1'b0, t);
      bus.in_valid = 1'b1;
      if (i > 0) begin
        ncmp++;
        if (t - tp !== 10) begin
          nfail++;
          $display("FAIL b2b_gap%0d: got %0d want 10", i, t - tp);
        end
      end
      tp = t;
      wait_out(n);
      ncmp++;
      if (bus.sum !== vs[i] || bus.cout !== vo[i]) begin
        nfail++;
        $display("FAIL b2b_sum%0d: got %h c%b want %h c%b",
                 i, bus.sum, bus.cout, vs[i], vo[i]);
      end
    end
    bus.in_valid = 1'b0;
    step();
    step();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub = 1'b0;
`endif
    bus.out_ready = 1'b1;
    test_reset();
    test_add(8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, 1'b0);
    test_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    test_add(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    test_add(8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1'b0);
`ifdef SERIAL_ADD_SUB_EN
    test_sub(8'h05, 8'h07, 8'hFE, 1'b0, 1'b0);
    test_sub(8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
`endif
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
